// File: rtl/div_issue_ctrl_pkg.sv
// Shared RV32M divide definitions: mode/funct3 encodings, sequencer states and
// mode decode helpers.
package m_ext_pkg;

    localparam int unsigned    XLEN_DEF  = 32;
    localparam logic [31:0]    XLEN_ONES = '1;

    localparam logic [2:0] F3_DIV  = 3'b100;
    localparam logic [2:0] F3_DIVU = 3'b101;
    localparam logic [2:0] F3_REM  = 3'b110;
    localparam logic [2:0] F3_REMU = 3'b111;

    typedef enum logic [1:0] {
        MODE_DIV  = 2'b00,
        MODE_DIVU = 2'b01,
        MODE_REM  = 2'b10,
        MODE_REMU = 2'b11
    } div_mode_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FAST,
        ST_BUSY,
        ST_DONE,
        ST_DRAIN
    } div_state_t;

    function automatic logic mode_is_rem(input logic [1:0] mode);
        return mode[1];
    endfunction

    function automatic logic mode_is_signed(input logic [1:0] mode);
        return ~mode[0];
    endfunction

endpackage

// File: rtl/div_issue_ctrl_if.sv
// EX-side, div_unit-side and writeback signals of the divide sequencer.
// master = sequencer, slave = surrounding pipeline / div_unit.
interface div_issue_ctrl_if #(
    parameter int unsigned XLEN = 32,
    parameter int unsigned RD_W = 5
) ();
    logic            ex_valid;
    logic [2:0]      ex_funct3;
    logic [XLEN-1:0] ex_rs1;
    logic [XLEN-1:0] ex_rs2;
    logic [RD_W-1:0] ex_rd;
    logic            flush;
    logic            ex_stall;
    logic            div_start;
    logic [XLEN-1:0] div_dividend;
    logic [XLEN-1:0] div_divisor;
    logic [1:0]      div_mode;
    logic [XLEN-1:0] div_result;
    logic            div_done;
    logic            wb_valid;
    logic [RD_W-1:0] wb_rd;
    logic [XLEN-1:0] wb_data;
    logic            timeout_err;

    modport master (
        input  ex_valid, ex_funct3, ex_rs1, ex_rs2, ex_rd, flush,
        input  div_result, div_done,
        output ex_stall, div_start, div_dividend, div_divisor, div_mode,
        output wb_valid, wb_rd, wb_data, timeout_err
    );

    modport slave (
        output ex_valid, ex_funct3, ex_rs1, ex_rs2, ex_rd, flush,
        output div_result, div_done,
        input  ex_stall, div_start, div_dividend, div_divisor, div_mode,
        input  wb_valid, wb_rd, wb_data, timeout_err
    );
endinterface

// File: rtl/div_issue_ctrl_special_case.sv
// Combinational RV32M special-case detect (divide by zero, signed overflow)
// and the architecturally defined result for those cases.
module div_special_case
    import m_ext_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic [XLEN-1:0] i_dividend,
    input  logic [XLEN-1:0] i_divisor,
    input  logic [1:0]      i_mode,
    output logic            o_special,
    output logic [XLEN-1:0] o_result
);
    logic [XLEN-1:0] w_int_min;
    logic            w_div_zero;
    logic            w_overflow;

    assign w_int_min  = {1'b1, {(XLEN-1){1'b0}}};
    assign w_div_zero = (i_divisor == '0);
    assign w_overflow = mode_is_signed(i_mode) && (i_dividend == w_int_min) &&
                        (i_divisor == '1);
    assign o_special  = w_div_zero || w_overflow;

    always_comb begin
        o_result = '0;
        if (w_div_zero) begin
            o_result = mode_is_rem(i_mode) ? i_dividend : '1;
        end else if (w_overflow) begin
            o_result = mode_is_rem(i_mode) ? '0 : w_int_min;
        end
    end
endmodule

// File: rtl/div_issue_ctrl.sv
// Issue sequencer between EX and div_unit: fast-path special cases, start/done
// handshake with watchdog, flush drain and single-cycle writeback strobe.
module div_issue_ctrl
    import m_ext_pkg::*;
#(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned RD_W    = 5,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic             clk,
    input  logic             rst,
    div_issue_ctrl_if.master bus
);
    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

    div_state_t      r_state;
    logic [CNT_W-1:0] r_cnt;
    logic            r_to_drain;
    logic [XLEN-1:0] r_dividend;
    logic [XLEN-1:0] r_divisor;
    logic [1:0]      r_mode;
    logic [RD_W-1:0] r_rd;
    logic [XLEN-1:0] r_wb_data;
    logic            r_wb_valid;
    logic            r_start;
    logic            r_timeout_err;

    logic            w_special;
    logic [XLEN-1:0] w_fast_result;
    logic            w_expired;
    logic            w_done_valid;
    logic            w_unused_f3;

    // funct3[2] is implied by ex_valid (only DIV/DIVU/REM/REMU are presented)
    assign w_unused_f3 = bus.ex_funct3[2];

    div_special_case #(.XLEN(XLEN)) u_special (
        .i_dividend (bus.ex_rs1),
        .i_divisor  (bus.ex_rs2),
        .i_mode     (bus.ex_funct3[1:0]),
        .o_special  (w_special),
        .o_result   (w_fast_result)
    );

    assign w_expired    = (r_cnt == CNT_W'(TIMEOUT - 1));
    // done seen in the start cycle may be left over from the previous op
    assign w_done_valid = bus.div_done && !r_start;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_cnt         <= '0;
            r_to_drain    <= 1'b0;
            r_dividend    <= '0;
            r_divisor     <= '0;
            r_mode        <= '0;
            r_rd          <= '0;
            r_wb_data     <= '0;
            r_wb_valid    <= 1'b0;
            r_start       <= 1'b0;
            r_timeout_err <= 1'b0;
        end else begin
            r_start    <= 1'b0;
            r_wb_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (bus.ex_valid && !bus.flush) begin
                        r_dividend <= bus.ex_rs1;
                        r_divisor  <= bus.ex_rs2;
                        r_mode     <= bus.ex_funct3[1:0];
                        r_rd       <= bus.ex_rd;
                        r_cnt      <= '0;
                        r_to_drain <= 1'b0;
                        if (w_special) begin
                            r_wb_data <= w_fast_result;
                            r_state   <= ST_FAST;
                        end else begin
                            r_start <= 1'b1;
                            r_state <= ST_BUSY;
                        end
                    end
                end
                ST_FAST: begin
                    r_wb_valid <= 1'b1;
                    r_state    <= ST_DONE;
                end
                ST_BUSY: begin
                    if (bus.flush) begin
                        // done already seen: div_unit is idle, nothing to drain
                        r_cnt   <= '0;
                        r_state <= w_done_valid ? ST_IDLE : ST_DRAIN;
                    end else if (w_done_valid) begin
                        r_wb_data  <= bus.div_result;
                        r_wb_valid <= 1'b1;
                        r_state    <= ST_DONE;
                    end else if (w_expired) begin
                        r_wb_data     <= '1;
                        r_timeout_err <= 1'b1;
                        r_to_drain    <= 1'b1;
                        r_cnt         <= '0;
                        r_state       <= ST_DRAIN;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_DRAIN: begin
                    if (bus.div_done || w_expired) begin
                        r_to_drain <= 1'b0;
                        if (r_to_drain) begin
                            r_wb_valid <= 1'b1;
                            r_state    <= ST_DONE;
                        end else begin
                            r_state <= ST_IDLE;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.ex_stall     = (bus.ex_valid && (r_state == ST_IDLE)) ||
                              (r_state inside {ST_FAST, ST_BUSY, ST_DRAIN});
    assign bus.div_start    = r_start;
    assign bus.div_dividend = r_dividend;
    assign bus.div_divisor  = r_divisor;
    assign bus.div_mode     = r_mode;
    assign bus.wb_valid     = r_wb_valid;
    assign bus.wb_rd        = r_rd;
    assign bus.wb_data      = r_wb_data;
    assign bus.timeout_err  = r_timeout_err;
endmodule

// File: tb/tb_div_issue_ctrl.sv
// Directed and randomized bench for div_issue_ctrl with a behavioural div_unit
// and an ISA-level result reference.
module tb_div_issue_ctrl;
    import m_ext_pkg::*;

    localparam int unsigned XLEN    = 32;
    localparam int unsigned RD_W    = 5;
    localparam int unsigned TIMEOUT = 64;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int unsigned checks = 0;
    int unsigned errors = 0;

    int unsigned m_lat   = 4;
    bit          m_never = 1'b0;
    bit          m_busy  = 1'b0;
    int unsigned m_cnt   = 0;
    logic [31:0] m_res   = '0;

    always #5 clk = ~clk;

    div_issue_ctrl_if #(.XLEN(XLEN), .RD_W(RD_W)) bus ();

    div_issue_ctrl #(.XLEN(XLEN), .RD_W(RD_W), .TIMEOUT(TIMEOUT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // RV32M architectural result
    function automatic logic [31:0] ref_result(input logic [2:0] f3, input logic [31:0] a,
                                               input logic [31:0] b);
        logic signed [31:0] sa;
        logic signed [31:0] sb;
        sa = a;
        sb = b;
        if (b == 32'd0) return (f3 == F3_REM || f3 == F3_REMU) ? a : XLEN_ONES;
        if ((f3 == F3_DIV || f3 == F3_REM) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
            return (f3 == F3_REM) ? 32'd0 : 32'h8000_0000;
        case (f3)
            F3_DIV:  return sa / sb;
            F3_DIVU: return a / b;
            F3_REM:  return sa % sb;
            default: return a % b;
        endcase
    endfunction

    function automatic bit is_fast(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        return (b == 32'd0) ||
               ((f3 == F3_DIV || f3 == F3_REM) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
    endfunction

    // div_unit: drops done one cycle after start, raises it after m_lat cycles, holds it
    always @(negedge clk or posedge rst) begin
        if (rst) begin
            bus.div_done   = 1'b0;
            bus.div_result = '0;
            m_busy         = 1'b0;
        end else if (bus.div_start) begin
            m_busy = 1'b1;
            m_cnt  = m_lat;
            m_res  = ref_result({1'b1, bus.div_mode}, bus.div_dividend, bus.div_divisor);
        end else if (m_busy) begin
            bus.div_done = 1'b0;
            if (m_cnt <= 1) begin
                m_busy = 1'b0;
                if (!m_never) begin
                    bus.div_done   = 1'b1;
                    bus.div_result = m_res;
                end
            end else begin
                m_cnt--;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic run_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] rd, input int unsigned lat,
                          input bit never, input int unsigned flush_cyc,
                          output int unsigned wb_cyc);
        logic [31:0] exp;
        bit          fast;
        int unsigned starts, stall_bad, hold_bad;
        exp       = never ? XLEN_ONES : ref_result(f3, a, b);
        fast      = is_fast(f3, a, b);
        starts    = 0;
        stall_bad = 0;
        hold_bad  = 0;
        wb_cyc    = 0;
        m_lat     = lat;
        m_never   = never;
        @(negedge clk);
        bus.ex_valid  = 1'b1;
        bus.ex_funct3 = f3;
        bus.ex_rs1    = a;
        bus.ex_rs2    = b;
        bus.ex_rd     = rd;
        #1 chk({tag, " stall_present"}, bus.ex_stall, 1);
        for (int unsigned c = 1; c <= 3 * TIMEOUT + 10; c++) begin
            @(negedge clk);
            bus.flush = (c == flush_cyc);
            starts += bus.div_start;
            if (bus.div_dividend !== a || bus.div_divisor !== b || bus.div_mode !== f3[1:0])
                hold_bad++;
            if (bus.wb_valid) begin
                wb_cyc = c;
                break;
            end
            if (!bus.ex_stall) stall_bad++;
        end
        bus.flush = 1'b0;
        chk({tag, " wb_seen"}, wb_cyc != 0, 1);
        chk({tag, " wb_data"}, bus.wb_data, exp);
        chk({tag, " wb_rd"}, bus.wb_rd, rd);
        chk({tag, " stall_in_done"}, bus.ex_stall, 0);
        chk({tag, " stall_while_busy"}, stall_bad, 0);
        chk({tag, " operand_hold"}, hold_bad, 0);
        chk({tag, " start_pulses"}, starts, fast ? 0 : 1);
        if (fast) chk({tag, " fast_latency"}, wb_cyc, 2);
        bus.ex_valid = 1'b0;
        @(negedge clk);
        chk({tag, " wb_one_cycle"}, bus.wb_valid, 0);
        chk({tag, " stall_idle"}, bus.ex_stall, 0);
    endtask

    task automatic run_flush(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                             input int unsigned lat, input int unsigned flush_at);
        int unsigned starts, wb_seen, drop_cyc;
        logic        done_at_drop;
        starts       = 0;
        wb_seen      = 0;
        drop_cyc     = 0;
        done_at_drop = 1'b0;
        m_lat        = lat;
        m_never      = 1'b0;
        @(negedge clk);
        bus.ex_valid  = 1'b1;
        bus.ex_funct3 = f3;
        bus.ex_rs1    = a;
        bus.ex_rs2    = b;
        bus.ex_rd     = 5'd9;
        for (int unsigned c = 1; c <= lat + TIMEOUT; c++) begin
            @(negedge clk);
            starts  += bus.div_start;
            wb_seen += bus.wb_valid;
            bus.flush = (c == flush_at);
            if (c == flush_at) bus.ex_valid = 1'b0;
            if (c > flush_at && !bus.ex_stall) begin
                drop_cyc     = c;
                done_at_drop = bus.div_done;
                break;
            end
        end
        bus.flush = 1'b0;
        chk("flush start_pulses", starts, 1);
        chk("flush no_wb", wb_seen, 0);
        chk("flush stall_released", drop_cyc != 0, 1);
        chk("flush stall_until_done", done_at_drop, 1);
        chk("flush drain_length", drop_cyc >= lat, 1);
    endtask

    initial begin
        int unsigned cyc;
        logic [2:0]  f3;
        logic [31:0] a, b;
        int unsigned sel, starts, wbs;

        bus.ex_valid  = 1'b0;
        bus.ex_funct3 = '0;
        bus.ex_rs1    = '0;
        bus.ex_rs2    = '0;
        bus.ex_rd     = '0;
        bus.flush     = 1'b0;
        #1;
        chk("reset ex_stall", bus.ex_stall, 0);
        chk("reset div_start", bus.div_start, 0);
        chk("reset dividend", bus.div_dividend, 0);
        chk("reset divisor", bus.div_divisor, 0);
        chk("reset wb_valid", bus.wb_valid, 0);
        chk("reset wb_data", bus.wb_data, 0);
        chk("reset timeout_err", bus.timeout_err, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        run_op("divu_300_10", F3_DIVU, 32'd300, 32'd10, 5'd5, 33, 1'b0, 0, cyc);
        run_op("div_55_0", F3_DIV, 32'd55, 32'd0, 5'd6, 33, 1'b0, 0, cyc);
        run_op("rem_50_0", F3_REM, 32'd50, 32'd0, 5'd7, 33, 1'b0, 0, cyc);
        run_op("div_ovf", F3_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 5'd8, 33, 1'b0, 1, cyc);
        run_op("rem_ovf", F3_REM, 32'h8000_0000, 32'hFFFF_FFFF, 5'd9, 33, 1'b0, 0, cyc);

        // op presented together with flush in IDLE is dropped
        @(negedge clk);
        bus.ex_valid = 1'b1;
        bus.flush    = 1'b1;
        bus.ex_rs1   = 32'd9;
        bus.ex_rs2   = 32'd3;
        @(negedge clk);
        bus.ex_valid = 1'b0;
        bus.flush    = 1'b0;
        starts = 0;
        wbs    = 0;
        for (int i = 0; i < 4; i++) begin
            starts += bus.div_start;
            wbs    += bus.wb_valid;
            @(negedge clk);
        end
        chk("idle_flush no_start", starts, 0);
        chk("idle_flush no_wb", wbs, 0);
        chk("idle_flush no_stall", bus.ex_stall, 0);

        run_flush(F3_DIV, 32'd1000, 32'd3, 33, 5);
        run_op("div_7_2", F3_DIV, 32'd7, 32'd2, 5'd10, 20, 1'b0, 0, cyc);
        run_op("div_stale_done", F3_DIV, 32'hFFFF_FF9C, 32'd7, 5'd11, 6, 1'b0, 0, cyc);

        for (int i = 0; i < 24; i++) begin
            f3  = 3'(4 + $urandom_range(0, 3));
            sel = $urandom_range(0, 9);
            a   = $urandom;
            b   = $urandom;
            if (sel == 0) b = 32'd0;
            else if (sel == 1) begin
                a = 32'h8000_0000;
                b = 32'hFFFF_FFFF;
            end else if (sel < 6) begin
                a = 32'($urandom_range(0, 2000)) - 32'd1000;
                b = 32'($urandom_range(0, 40)) - 32'd20;
            end
            run_op("random", f3, a, b, 5'($urandom), $urandom_range(2, 12), 1'b0, 0, cyc);
        end

        chk("pre_timeout err_clear", bus.timeout_err, 0);
        run_op("timeout", F3_DIVU, 32'd12345, 32'd7, 5'd12, 4, 1'b1, 0, cyc);
        chk("timeout err_set", bus.timeout_err, 1);
        chk("timeout after_watchdog", cyc > TIMEOUT, 1);
        run_op("after_timeout", F3_REMU, 32'd100, 32'd7, 5'd13, 5, 1'b0, 0, cyc);
        chk("timeout err_sticky", bus.timeout_err, 1);

        // asynchronous reset mid-BUSY
        m_lat   = 33;
        m_never = 1'b0;
        @(negedge clk);
        bus.ex_valid  = 1'b1;
        bus.ex_funct3 = F3_DIV;
        bus.ex_rs1    = 32'd500;
        bus.ex_rs2    = 32'd9;
        bus.ex_rd     = 5'd14;
        repeat (3) @(negedge clk);
        chk("pre_reset busy_stall", bus.ex_stall, 1);
        #2;
        rst          = 1'b1;
        bus.ex_valid = 1'b0;
        #1;
        chk("async_rst ex_stall", bus.ex_stall, 0);
        chk("async_rst dividend", bus.div_dividend, 0);
        chk("async_rst divisor", bus.div_divisor, 0);
        chk("async_rst wb_rd", bus.wb_rd, 0);
        chk("async_rst wb_data", bus.wb_data, 0);
        chk("async_rst timeout_err", bus.timeout_err, 0);
        @(negedge clk);
        rst = 1'b0;
        run_op("post_reset", F3_DIVU, 32'd81, 32'd9, 5'd15, 3, 1'b0, 0, cyc);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
